// File: rtl/mac_rx_ingress.sv
// mac_rx_ingress: MAC Avalon-ST beats to input FIFO with framing, length limit, discard and statistics
module mac_rx_ingress #(
   parameter int DATA_W    = 32,
   parameter int MAX_WORDS = 380,
   parameter int CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] mac_data,
   input  logic              mac_valid,
   input  logic              mac_sop,
   input  logic              mac_eop,
   input  logic              mac_error,
   output logic              mac_ready,
   input  logic              wrfull,
   output logic              wrreq,
   output logic [DATA_W+1:0] wrdata,
   output logic              frame_done,
   output logic              frame_err,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              busy
);
   localparam int LEN_W = $clog2(MAX_WORDS + 1);
   typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;
   state_t r_state, w_next;
   logic [LEN_W-1:0] r_len, w_len_next;
   logic w_xfer, w_wr, w_eop, w_err, w_drop;
   assign mac_ready = r_state == DISCARD ? 1'b1 : r_state == RECV ? ~wrfull : en & ~wrfull;
   assign w_xfer = mac_valid & mac_ready;
   assign wrreq = w_xfer & w_wr & ~rst;
   assign wrdata = {w_err, w_eop, mac_data};
   assign busy = r_state != IDLE;
   always_comb begin
      w_next = r_state;
      w_len_next = r_len;
      w_wr = 1'b0;
      w_eop = 1'b0;
      w_err = 1'b0;
      w_drop = 1'b0;
      case (r_state)
         IDLE: if (w_xfer) begin
            if (mac_sop) begin
               w_wr = 1'b1;
               w_eop = mac_eop;
               w_err = mac_eop & mac_error;
               w_len_next = LEN_W'(1);
               w_next = mac_eop ? IDLE : RECV;
            end else w_drop = 1'b1;
         end
         RECV: if (w_xfer) begin
            w_wr = 1'b1;
            if (mac_sop) begin
               // previous frame lost its eop: close it as bad on this beat
               w_err = 1'b1;
               w_eop = 1'b1;
               w_next = mac_eop ? IDLE : DISCARD;
            end else if (mac_eop) begin
               w_err = mac_error;
               w_eop = 1'b1;
               w_next = IDLE;
            end else if (r_len == LEN_W'(MAX_WORDS - 1)) begin
               w_err = 1'b1;
               w_eop = 1'b1;
               w_next = DISCARD;
            end else w_len_next = r_len + LEN_W'(1);
         end
         DISCARD: if (w_xfer) begin
            w_drop = 1'b1;
            w_next = mac_eop ? IDLE : DISCARD;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_len <= '0;
         frame_done <= 1'b0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
         err_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         r_state <= w_next;
         r_len <= w_len_next;
         frame_done <= wrreq & w_eop;
         frame_err <= wrreq & w_eop & w_err;
         frame_cnt <= frame_cnt + CNT_W'(wrreq & w_eop);
         err_cnt <= err_cnt + CNT_W'(wrreq & w_eop & w_err);
         drop_cnt <= drop_cnt + CNT_W'(w_xfer & w_drop);
      end
   end
endmodule

// File: tb/tb_mac_rx_ingress.sv
// tb_mac_rx_ingress: directed table and sequence checks for mac_rx_ingress
module tb_mac_rx_ingress;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1;
   logic [31:0] mac_data = '0;
   logic mac_valid = 1'b0, mac_sop = 1'b0, mac_eop = 1'b0, mac_error = 1'b0;
   logic mac_ready, wrfull = 1'b0, wrreq, frame_done, frame_err, busy;
   logic [33:0] wrdata;
   logic [31:0] frame_cnt, err_cnt, drop_cnt;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   mac_rx_ingress dut (
      .clk(clk), .rst(rst), .en(en), .mac_data(mac_data), .mac_valid(mac_valid),
      .mac_sop(mac_sop), .mac_eop(mac_eop), .mac_error(mac_error), .mac_ready(mac_ready),
      .wrfull(wrfull), .wrreq(wrreq), .wrdata(wrdata), .frame_done(frame_done),
      .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
      .drop_cnt(drop_cnt), .busy(busy)
   );
   typedef struct {
      logic sop, eop, err;
      logic [31:0] data;
      logic x_wr;
      logic [33:0] x_word;
      logic x_done, x_ferr;
   } vec_t;
   vec_t tbl[10];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   task automatic beat(input logic s, input logic e, input logic er, input logic [31:0] d, input logic wf);
      @(negedge clk);
      mac_valid = 1'b1; mac_sop = s; mac_eop = e; mac_error = er; mac_data = d; wrfull = wf;
      #1;
   endtask
   task automatic idle();
      @(negedge clk);
      mac_valid = 1'b0; mac_sop = 1'b0; mac_eop = 1'b0; mac_error = 1'b0; wrfull = 1'b0;
      #1;
   endtask
   task automatic do_reset();
      idle();
      rst = 1'b1; en = 1'b1;
      idle();
      idle();
      rst = 1'b0;
   endtask
   initial begin
      int nwr;
      tbl[0] = '{1, 0, 0, 32'h11, 1, {2'b00, 32'h11}, 0, 0};
      tbl[1] = '{0, 0, 0, 32'h22, 1, {2'b00, 32'h22}, 0, 0};
      tbl[2] = '{0, 0, 0, 32'h33, 1, {2'b00, 32'h33}, 0, 0};
      tbl[3] = '{0, 1, 0, 32'h44, 1, {2'b01, 32'h44}, 0, 0};
      tbl[4] = '{1, 0, 0, 32'h11, 1, {2'b00, 32'h11}, 1, 0};
      tbl[5] = '{0, 0, 0, 32'h22, 1, {2'b00, 32'h22}, 0, 0};
      tbl[6] = '{0, 0, 0, 32'h33, 1, {2'b00, 32'h33}, 0, 0};
      tbl[7] = '{0, 1, 1, 32'h44, 1, {2'b11, 32'h44}, 0, 0};
      tbl[8] = '{1, 1, 1, 32'h55, 1, {2'b11, 32'h55}, 1, 1};
      tbl[9] = '{1, 1, 0, 32'h66, 1, {2'b01, 32'h66}, 1, 1};
      // reset state, with a sop beat offered while rst is high
      beat(1, 0, 0, 32'h99, 0);
      chk("rst_wrreq", 64'(wrreq), 0);
      chk("rst_ready", 64'(mac_ready), 1);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_frame_cnt", 64'(frame_cnt), 0);
      chk("rst_drop_cnt", 64'(drop_cnt), 0);
      chk("rst_done", 64'(frame_done), 0);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         beat(tbl[i].sop, tbl[i].eop, tbl[i].err, tbl[i].data, 0);
         chk($sformatf("tbl%0d_wrreq", i), 64'(wrreq), 64'(tbl[i].x_wr));
         chk($sformatf("tbl%0d_word", i), 64'(wrdata), 64'(tbl[i].x_word));
         chk($sformatf("tbl%0d_done", i), 64'(frame_done), 64'(tbl[i].x_done));
         chk($sformatf("tbl%0d_ferr", i), 64'(frame_err), 64'(tbl[i].x_ferr));
      end
      idle();
      chk("tbl_last_done", 64'(frame_done), 1);
      chk("tbl_last_ferr", 64'(frame_err), 0);
      idle();
      chk("tbl_done_clear", 64'(frame_done), 0);
      chk("tbl_frame_cnt", 64'(frame_cnt), 4);
      chk("tbl_err_cnt", 64'(err_cnt), 2);
      chk("tbl_drop_cnt", 64'(drop_cnt), 0);
      // 385-beat frame truncated at 380
      do_reset();
      nwr = 0;
      for (int i = 1; i <= 385; i++) begin
         beat(i == 1, i == 385, 0, 32'(i), 0);
         nwr += int'(wrreq);
         if (i == 379) chk("long_379_word", 64'(wrdata), {30'd0, 2'b00, 32'd379});
         if (i == 380) chk("long_trunc_word", 64'(wrdata), {30'd0, 2'b11, 32'd380});
         if (i == 381) chk("long_discard_busy", 64'(busy), 1);
         if (i > 380) chk($sformatf("long_drop%0d", i), 64'(wrreq), 0);
      end
      idle();
      chk("long_writes", 64'(nwr), 380);
      chk("long_drop_cnt", 64'(drop_cnt), 5);
      chk("long_idle", 64'(busy), 0);
      chk("long_frame_cnt", 64'(frame_cnt), 1);
      chk("long_err_cnt", 64'(err_cnt), 1);
      // sop arriving mid-frame closes the old frame as bad and discards the rest
      do_reset();
      beat(1, 0, 0, 32'hA1, 0);
      beat(0, 0, 0, 32'hA2, 0);
      beat(1, 0, 0, 32'hA3, 0);
      chk("sop_mid_wrreq", 64'(wrreq), 1);
      chk("sop_mid_word", 64'(wrdata), {30'd0, 2'b11, 32'hA3});
      nwr = 0;
      beat(0, 0, 0, 32'hA4, 0); nwr += int'(wrreq);
      beat(1, 0, 0, 32'hA5, 0); nwr += int'(wrreq);
      beat(0, 1, 0, 32'hA6, 0); nwr += int'(wrreq);
      idle();
      chk("sop_mid_no_writes", 64'(nwr), 0);
      chk("sop_mid_drop_cnt", 64'(drop_cnt), 3);
      chk("sop_mid_err_cnt", 64'(err_cnt), 1);
      chk("sop_mid_frame_cnt", 64'(frame_cnt), 1);
      chk("sop_mid_idle", 64'(busy), 0);
      // wrfull stall for 10 cycles mid-frame
      do_reset();
      nwr = 0;
      beat(1, 0, 0, 32'hB1, 0); nwr += int'(wrreq);
      beat(0, 0, 0, 32'hB2, 0); nwr += int'(wrreq);
      for (int i = 0; i < 10; i++) begin
         beat(0, 0, 0, 32'hB3, 1);
         chk($sformatf("stall%0d_ready", i), 64'(mac_ready), 0);
         chk($sformatf("stall%0d_wrreq", i), 64'(wrreq), 0);
      end
      beat(0, 0, 0, 32'hB3, 0); nwr += int'(wrreq);
      chk("stall_resume_word", 64'(wrdata), {30'd0, 2'b00, 32'hB3});
      beat(0, 1, 0, 32'hB4, 0); nwr += int'(wrreq);
      chk("stall_eop_word", 64'(wrdata), {30'd0, 2'b01, 32'hB4});
      idle();
      chk("stall_writes", 64'(nwr), 4);
      chk("stall_frame_cnt", 64'(frame_cnt), 1);
      chk("stall_drop_cnt", 64'(drop_cnt), 0);
      // stray beats in IDLE, then a sop held off by en=0
      do_reset();
      nwr = 0;
      for (int i = 0; i < 3; i++) begin
         beat(0, 0, 0, 32'(i), 0);
         nwr += int'(wrreq);
      end
      idle();
      chk("stray_no_writes", 64'(nwr), 0);
      chk("stray_drop_cnt", 64'(drop_cnt), 3);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         beat(1, 0, 0, 32'hC1, 0);
         chk($sformatf("en_off%0d_ready", i), 64'(mac_ready), 0);
         chk($sformatf("en_off%0d_wrreq", i), 64'(wrreq), 0);
      end
      en = 1'b1;
      #1;
      chk("en_on_ready", 64'(mac_ready), 1);
      chk("en_on_word", 64'(wrdata), {30'd0, 2'b00, 32'hC1});
      chk("en_on_wrreq", 64'(wrreq), 1);
      beat(0, 1, 0, 32'hC2, 0);
      en = 1'b0;
      #1;
      chk("en_midframe_ready", 64'(mac_ready), 1);
      chk("en_midframe_word", 64'(wrdata), {30'd0, 2'b01, 32'hC2});
      idle();
      chk("en_frame_cnt", 64'(frame_cnt), 1);
      chk("en_drop_cnt", 64'(drop_cnt), 3);
      chk("en_idle", 64'(busy), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
